// File: rtl/codix_risc_port_out_collector.sv
// codix_risc_port_out_collector
//
// Captures every word the codix_risc platform writes to its output port into
// a FIFO and replays it to the IA-vs-CA comparator over a valid/ready stream.
// It also tracks termination: after halt the FIFO drains and done is raised.
// The first non-zero error code is latched, and a sticky flag records any
// capture that was dropped because the FIFO was full.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST          asynchronous, active-low reset
//   port_out     platform output-port data
//   port_out_en  platform output-port write strobe, one word per high cycle
//   port_halt    platform halt indication (level)
//   port_error   platform error code, 0 means no error
//   tx_data      head-of-FIFO word (0 when the FIFO is empty)
//   tx_valid     tx_data valid (FIFO not empty)
//   tx_ready     consumer accepts the word when tx_valid && tx_ready
//   tx_last      final word after halt is being presented
//   done         halt seen and FIFO fully drained, sticky until reset
//   overflow     sticky, a capture was attempted while the FIFO was full
//   err_valid    sticky, a non-zero port_error has been seen
//   err_code     first non-zero port_error value
//   word_cnt     number of words captured into the FIFO (wraps)
//   level        current FIFO occupancy

module codix_risc_port_out_collector #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [31:0]              port_out,
  input  logic                     port_out_en,
  input  logic                     port_halt,
  input  logic [31:0]              port_error,
  output logic [31:0]              tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_last,
  output logic                     done,
  output logic                     overflow,
  output logic                     err_valid,
  output logic [31:0]              err_code,
  output logic [CNT_W-1:0]         word_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Pointers carry one extra wrap bit so that the difference tells a full
  // FIFO apart from an empty one.
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [31:0]  mem [DEPTH];

  logic         full;
  logic         pop;
  logic         push_req;
  logic         push;
  logic         ovf_evt;
  logic [AW:0]  level_nxt;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LEVEL);
  assign tx_valid = (level != '0);
  assign tx_data  = tx_valid ? mem[rd_ptr[AW-1:0]] : 32'd0;
  assign pop      = tx_valid & tx_ready;

  // Capture only happens in RUN; this includes the halt cycle itself because
  // the state only leaves RUN on the following edge. A full FIFO still
  // accepts the word when the head is popped in the same cycle.
  assign push_req = (state == RUN) & port_out_en;
  assign push     = push_req & (~full | pop);
  assign ovf_evt  = push_req & full & ~pop;

  assign done     = (state == DONE);
  assign tx_last  = tx_valid & (state != RUN) & (level == (AW+1)'(1));

  // Next-state logic. DRAIN looks at the post-update occupancy so that done
  // rises on the edge right after the last word is popped.
  always_comb begin
    state_nxt = state;
    level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);
    case (state)
      RUN:     if (port_halt) state_nxt = DRAIN;
      DRAIN:   if (level_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO pointers, capture counter and sticky overflow flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + (AW+1)'(1);
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (ovf_evt) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array is not reset; the pointers alone define which entries hold
  // valid data.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= port_out;
    end
  end

  // The first non-zero error code is kept; later codes are ignored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_valid <= 1'b0;
      err_code  <= 32'd0;
    end else if (!err_valid && (port_error != 32'd0)) begin
      err_valid <= 1'b1;
      err_code  <= port_error;
    end
  end

endmodule

// File: tb/tb_codix_risc_port_out_collector.sv
// tb_codix_risc_port_out_collector
//
// Directed bench for codix_risc_port_out_collector with DEPTH=16, CNT_W=32.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, after the edge has taken effect.

module tb_codix_risc_port_out_collector;

  logic        CLK;
  logic        RST;
  logic [31:0] port_out;
  logic        port_out_en;
  logic        port_halt;
  logic [31:0] port_error;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        done;
  logic        overflow;
  logic        err_valid;
  logic [31:0] err_code;
  logic [31:0] word_cnt;
  logic [4:0]  level;

  int evalCount = 0;
  int failCount = 0;

  codix_risc_port_out_collector #(.DEPTH(16), .CNT_W(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .port_out    (port_out),
    .port_out_en (port_out_en),
    .port_halt   (port_halt),
    .port_error  (port_error),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .done        (done),
    .overflow    (overflow),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .word_cnt    (word_cnt),
    .level       (level)
  );

  // 10-unit clock period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the platform-side and consumer-side inputs.
  task automatic applyStimulus(input logic en, input logic [31:0] data,
                               input logic halt, input logic ready);
    port_out_en = en;
    port_out    = data;
    port_halt   = halt;
    tx_ready    = ready;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Apply reset off the clock edge and release it after two edges.
  task automatic doReset();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    port_error = 32'd0;
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    port_error = 32'd0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    #2;

    // Reset state.
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_cnt", word_cnt, 32'd0);
    checkOutput("rst_errv", 32'(err_valid), 32'd0);
    checkOutput("rst_last", 32'(tx_last), 32'd0);
    doReset();

    // Three words streamed through, halt arrives with the third one.
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b1);
    tick();
    checkOutput("t1_data0", tx_data, 32'h11);
    checkOutput("t1_valid0", 32'(tx_valid), 32'd1);
    checkOutput("t1_last0", 32'(tx_last), 32'd0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b1);
    tick();
    checkOutput("t1_data1", tx_data, 32'h22);
    checkOutput("t1_level1", 32'(level), 32'd1);
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b1);
    tick();
    checkOutput("t1_data2", tx_data, 32'h33);
    checkOutput("t1_last2", 32'(tx_last), 32'd1);
    checkOutput("t1_done2", 32'(done), 32'd0);
    checkOutput("t1_cnt", word_cnt, 32'd3);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_valid_end", 32'(tx_valid), 32'd0);
    tick();
    checkOutput("t1_done_sticky", 32'(done), 32'd1);

    // Fill 16 with the consumer stalled, then one more write overflows.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("t2_level_full", 32'(level), 32'd16);
    checkOutput("t2_ovf_none", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
    tick();
    checkOutput("t2_ovf", 32'(overflow), 32'd1);
    checkOutput("t2_level", 32'(level), 32'd16);
    checkOutput("t2_cnt", word_cnt, 32'd16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t2_drain", tx_data, 32'h100 + 32'(i));
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
      tick();
    end
    checkOutput("t2_empty", 32'(tx_valid), 32'd0);
    checkOutput("t2_level_end", 32'(level), 32'd0);

    // Full FIFO with push and pop in the same cycle.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'hBEEF, 1'b0, 1'b1);
    tick();
    checkOutput("t3_level", 32'(level), 32'd16);
    checkOutput("t3_ovf", 32'(overflow), 32'd0);
    checkOutput("t3_head", tx_data, 32'h201);
    checkOutput("t3_cnt", word_cnt, 32'd17);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("t3_tail", tx_data, 32'hBEEF);
    checkOutput("t3_tail_level", 32'(level), 32'd1);

    // Error latching keeps the first non-zero code.
    doReset();
    port_error = 32'h0;
    tick();
    checkOutput("t4_errv0", 32'(err_valid), 32'd0);
    port_error = 32'h5;
    tick();
    checkOutput("t4_errv1", 32'(err_valid), 32'd1);
    checkOutput("t4_code1", err_code, 32'h5);
    port_error = 32'h9;
    tick();
    checkOutput("t4_code2", err_code, 32'h5);
    port_error = 32'h0;

    // Halt with an empty FIFO and no write.
    doReset();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    tick();
    checkOutput("t5_valid", 32'(tx_valid), 32'd0);
    checkOutput("t5_done_early", 32'(done), 32'd0);
    checkOutput("t5_last", 32'(tx_last), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    checkOutput("t5_done", 32'(done), 32'd1);
    checkOutput("t5_valid_end", 32'(tx_valid), 32'd0);

    // Halt together with a write; later writes are ignored.
    doReset();
    applyStimulus(1'b1, 32'hAB, 1'b1, 1'b0);
    tick();
    checkOutput("t6_data", tx_data, 32'hAB);
    checkOutput("t6_last", 32'(tx_last), 32'd1);
    applyStimulus(1'b1, 32'hCC, 1'b0, 1'b0);
    tick();
    checkOutput("t6_level", 32'(level), 32'd1);
    checkOutput("t6_cnt", word_cnt, 32'd1);
    applyStimulus(1'b1, 32'hDD, 1'b0, 1'b1);
    tick();
    checkOutput("t6_done", 32'(done), 32'd1);
    checkOutput("t6_level_end", 32'(level), 32'd0);
    checkOutput("t6_ovf", 32'(overflow), 32'd0);
    checkOutput("t6_cnt_end", word_cnt, 32'd1);

    // Mid-operation reset while holding 5 words with overflow set.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) tick();
    checkOutput("t7_level_pre", 32'(level), 32'd5);
    checkOutput("t7_ovf_pre", 32'(overflow), 32'd1);
    RST = 1'b0;
    #1;
    checkOutput("t7_level", 32'(level), 32'd0);
    checkOutput("t7_ovf", 32'(overflow), 32'd0);
    checkOutput("t7_cnt", word_cnt, 32'd0);
    checkOutput("t7_valid", 32'(tx_valid), 32'd0);
    tick();
    checkOutput("t7_level_held", 32'(level), 32'd0);
    RST = 1'b1;
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0);
    tick();
    checkOutput("t7_resume_data", tx_data, 32'h77);
    checkOutput("t7_resume_cnt", word_cnt, 32'd1);
    checkOutput("t7_resume_level", 32'(level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
    $finish;
  end

endmodule

// File: doc/codix_risc_port_out_collector.md
Name: codix_risc_port_out_collector

Overview:
- Sits directly downstream of the codix_risc platform (RTL CA model or golden IA model) in the IA-vs-CA verification harness.
- Captures every word the core writes to its output port (port_out qualified by port_out_en) into a FIFO and replays it to the comparator over a valid/ready stream.
- Tracks halt and error termination: drains cleanly after halt, records the first non-zero error code, and flags FIFO overflow so the comparator never silently loses words.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, 32, width of the captured-word counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous assert, active-low.
- port_out  in  32  platform output-port data.
- port_out_en  in  1  platform output-port write strobe; one word per high cycle.
- port_halt  in  1  platform halt indication; level.
- port_error  in  32  platform error code; 0 means no error.
- tx_data  out  32  head-of-FIFO word.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  consumer accepts the word when tx_valid and tx_ready are both high.
- tx_last  out  1  high with tx_valid when the presented word is the final word after halt.
- done  out  1  halt seen and FIFO fully drained; sticky until reset.
- overflow  out  1  sticky; a capture was attempted while the FIFO was full.
- err_valid  out  1  sticky; a non-zero port_error has been seen.
- err_code  out  32  first non-zero port_error value.
- word_cnt  out  CNT_W  number of words captured into the FIFO.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RST low, asynchronous): all outputs go to 0, FIFO is emptied, and the state machine enters RUN.

State machine:
- RUN: capture is enabled. When port_halt is sampled high, go to DRAIN.
  - A write with port_out_en high in the same cycle as the halt is still captured.
- DRAIN: capture is disabled; port_out_en is ignored and does not set overflow. When the FIFO becomes empty (level == 0 after the update), go to DONE.
- DONE: done = 1. The block stays in DONE until reset; port_halt deasserting does not leave DONE.

Capture (RUN, or the halt cycle itself):
- When port_out_en is high and the FIFO is not full, or is full but popping in the same cycle, write port_out and increment word_cnt.
- When port_out_en is high and the FIFO is full with no pop: drop the word, set overflow, leave word_cnt unchanged.
- word_cnt wraps modulo 2^CNT_W.

Output stream:
- tx_valid = (level != 0); registered FIFO, first-word latency is 1 cycle (capture in cycle N, tx_valid in N+1).
- tx_data is stable while tx_valid is high and tx_ready is low.
- Simultaneous push and pop when full is allowed: level stays at DEPTH and no overflow occurs.
- Simultaneous push and pop when empty: the word is not bypassed; it appears next cycle.
- tx_last = tx_valid and (state != RUN) and (level == 1).
  - If halt arrives with the FIFO empty and no same-cycle write, no word carries tx_last. DRAIN takes one cycle, then DONE.

Errors:
- On the first cycle port_error != 0: latch err_code and set err_valid.
- Later values are ignored.
- Error does not stop capture.

Pointers:
- Read and write pointers wrap at DEPTH.
- level is computed from the pointer difference plus an extra wrap bit, and is exact at 0 and DEPTH.

Mid-operation reset:
- Asserting RST at any time discards FIFO contents and all sticky flags in the same cycle.
- No tx handshake completes while RST is low.

Test Plan:
- Write 3 words (0x11, 0x22, 0x33) on consecutive cycles with tx_ready=1, then halt -> words delivered in order, each 1 cycle after capture; tx_last on 0x33; done 1 cycle after the last pop; word_cnt=3.
- tx_ready=0, DEPTH=16, 17 writes -> level=16, overflow=1 on the 17th write, word_cnt=16; then tx_ready=1 -> exactly the first 16 words delivered.
- FIFO full, port_out_en=1 and tx_ready=1 in the same cycle -> no overflow, level stays 16, new word ends up last.
- port_error sequence 0, 0x5, 0x9 -> err_valid rises with err_code=0x5 and stays at 0x5.
- Halt with FIFO empty and no write -> tx_valid never rises, tx_last never asserted, done=1 two cycles after halt is sampled.
- Halt with port_out_en in the same cycle (data 0xAB), writes in later cycles -> 0xAB delivered with tx_last; later writes ignored, overflow stays 0.
- Reset pulse while holding 5 words and overflow=1 -> level, overflow, word_cnt and tx_valid go to 0 immediately; capture resumes in RUN.
